nco_pitch_sequencer: RTL

Transmit side of the NCO pitch/reset interface. Keeps a phase-increment base per voice, computed from MIDI note number, and a signed detune per oscillator slot. It scans all VOICES x V_OSC slots continuously and drives vx, ox, osc_pitch_val and osc_accum_zero into the nco block. Note events arrive through a valid/ready handshake from the voice allocator. Detune is written through a simple write strobe from the parameter bus.

---
 rtl/nco_pitch_sequencer_pkg.sv | 12 +
 rtl/nco_pitch_sequencer_note_to_inc.sv | 32 +++
 rtl/nco_pitch_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/nco_pitch_sequencer_pkg.sv
// nco_pkg: shared constants, note FSM states and pitch saturation for the NCO pitch sequencer
package nco_pkg;
  localparam int NOTES_PER_OCT = 12;
  localparam logic [23:0] NOTE_TBL [12] = '{
    24'h800000, 24'h879C7D, 24'h8FACD6, 24'h9837F0, 24'hA14518, 24'hAADC08,
    24'hB504F3, 24'hBFC887, 24'hCB2FF5, 24'hD744FD, 24'hE411F0, 24'hF1A1BF
  };
  typedef enum logic [1:0] {IDLE, DIV, LOOKUP, WRITE} note_state_t;
  function automatic logic [23:0] sat24(input logic signed [25:0] s);
    return s < 0 ? 24'd0 : (s > 26'sh0FFFFFF ? 24'hFFFFFF : s[23:0]);
  endfunction
endpackage

// File: rtl/nco_pitch_sequencer_note_to_inc.sv
// note_to_inc: splits a MIDI note into octave/semitone by repeated subtraction and looks up its phase increment
module note_to_inc import nco_pkg::*; (
  input  logic        OSC_CLK,
  input  logic        reg_reset,
  input  logic        start,
  input  logic        step,
  input  logic        lookup,
  input  logic [6:0]  note,
  output logic        done,
  output logic [23:0] inc
);
  logic [6:0] rem;
  logic [3:0] oct;
  assign done = rem < 7'(NOTES_PER_OCT);
  // one subtraction per step; the top octave (10) uses the table unshifted
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) begin
      rem <= '0;
      oct <= '0;
      inc <= '0;
    end else begin
      if (start) begin
        rem <= note;
        oct <= '0;
      end else if (step && !done) begin
        rem <= rem - 7'(NOTES_PER_OCT);
        oct <= oct + 4'd1;
      end
      if (lookup) inc <= NOTE_TBL[rem[3:0]] >> (4'd10 - oct);
    end
  end
endmodule

// File: rtl/nco_pitch_sequencer.sv
// nco_pitch_sequencer: scans voice/oscillator slots and drives per-slot phase increments and accumulator-zero requests
module nco_pitch_sequencer import nco_pkg::*; #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2,
  parameter int DET_W   = 12
) (
  input  logic               OSC_CLK,
  input  logic               reg_reset,
  input  logic               scan_en,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [V_WIDTH-1:0] note_voice,
  input  logic [6:0]         note_num,
  input  logic               note_on,
  input  logic               det_we,
  input  logic [O_WIDTH-1:0] det_ox,
  input  logic [DET_W-1:0]   det_val,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic [23:0]        osc_pitch_val,
  output logic [VOICES-1:0]  osc_accum_zero,
  output logic               frame_start
);
  note_state_t state, state_nx;
  logic [V_WIDTH-1:0] v, voice;
  logic [O_WIDTH-1:0] o;
  logic on, accept, slot0, start, step, lookup, done;
  logic [23:0] inc;
  logic [23:0] base [VOICES];
  logic signed [DET_W-1:0] det [V_OSC];
  logic [VOICES-1:0] pending, zero_frame, set_mask;
  assign note_ready = state == IDLE;
  assign accept = note_valid && note_ready;
  assign slot0 = scan_en && v == '0 && o == '0;
  assign osc_accum_zero = zero_frame;
  assign set_mask = (state == WRITE && on) ? VOICES'(1) << voice : '0;
  note_to_inc u_note_to_inc (
    .OSC_CLK(OSC_CLK), .reg_reset(reg_reset), .start(start), .step(step),
    .lookup(lookup), .note(note_num), .done(done), .inc(inc)
  );
  // note FSM state register
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) state <= IDLE;
    else state <= state_nx;
  end
  // note FSM next state and datapath controls
  always_comb begin
    start = accept;
    step = state == DIV;
    lookup = state == LOOKUP;
    state_nx = state == IDLE   ? (accept ? DIV : IDLE) :
               state == DIV    ? (done ? LOOKUP : DIV) :
               state == LOOKUP ? WRITE : IDLE;
  end
  // capture target voice and on/off flag of an accepted note
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) begin
      voice <= '0;
      on <= 1'b0;
    end else if (accept) begin
      voice <= note_voice;
      on <= note_on;
    end
  end
  // per-voice base increment; note-off silences the voice
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) base <= '{default: '0};
    else if (state == WRITE) base[voice] <= on ? inc : '0;
  end
  // per-oscillator signed detune, writable at any time
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) det <= '{default: '0};
    else if (det_we) det[det_ox] <= det_val;
  end
  // slot scan counter, oscillator index carries into voice index
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) begin
      v <= '0;
      o <= '0;
    end else if (scan_en) begin
      o <= o == O_WIDTH'(V_OSC - 1) ? '0 : o + 1'b1;
      v <= o != O_WIDTH'(V_OSC - 1) ? v : (v == V_WIDTH'(VOICES - 1) ? '0 : v + 1'b1);
    end
  end
  // frame-aligned zero requests; a request set on the latch cycle lands in the next frame
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) begin
      pending <= '0;
      zero_frame <= '0;
    end else begin
      if (slot0) zero_frame <= pending;
      pending <= (slot0 ? '0 : pending) | set_mask;
    end
  end
  // one-cycle output pipeline, frozen while scanning is paused
  always_ff @(posedge OSC_CLK or posedge reg_reset) begin
    if (reg_reset) begin
      vx <= '0;
      ox <= '0;
      osc_pitch_val <= '0;
      frame_start <= 1'b0;
    end else if (scan_en) begin
      vx <= v;
      ox <= o;
      frame_start <= v == '0 && o == '0;
      osc_pitch_val <= sat24($signed({2'b00, base[v]}) + 26'(det[o]));
    end
  end
endmodule
